// File: rtl/fir_loop_sequencer.sv
// Top-level ap_ctrl_hs sequencer for the FIR datapath: runs LOAD then MAC,
// publishes saturating per-phase latencies and a per-phase timeout watchdog.
module fir_loop_sequencer #(
   parameter int CNT_W   = 32,
   parameter int NTAPS_W = 8,
   parameter int TIMEOUT = 65536
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic               ap_start,
   output logic               ap_done,
   output logic               ap_idle,
   output logic               ap_ready,
   input  logic [NTAPS_W-1:0] cfg_ntaps,
   output logic               ld_start,
   input  logic               ld_ready,
   input  logic               ld_done,
   output logic               mac_start,
   input  logic               mac_ready,
   input  logic               mac_done,
   output logic [NTAPS_W-1:0] mac_ntaps,
   output logic [CNT_W-1:0]   lat_load,
   output logic [CNT_W-1:0]   lat_mac,
   output logic [CNT_W-1:0]   lat_total,
   output logic               lat_valid,
   output logic               err_timeout,
   input  logic               err_clr
);

   typedef enum logic [2:0] {
      S_IDLE, S_LD_START, S_LD_WAIT, S_MAC_START, S_MAC_WAIT, S_DONE, S_ERROR
   } state_t;

   localparam logic [63:0] TO64 = 64'(TIMEOUT);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt_ld, r_cnt_mac, r_cnt_tot;
   logic [CNT_W-1:0]   w_ld_nxt, w_mac_nxt, w_tot_nxt, w_phase_nxt;
   logic [NTAPS_W-1:0] r_ntaps;
   logic [CNT_W-1:0]   r_lat_load, r_lat_mac, r_lat_total;
   logic               w_in_ld, w_in_mac, w_busy, w_wd_hit, w_skip_mac, w_enter_done;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_in_ld     = (r_state == S_LD_START)  || (r_state == S_LD_WAIT);
   assign w_in_mac    = (r_state == S_MAC_START) || (r_state == S_MAC_WAIT);
   assign w_busy      = (r_state != S_IDLE) && (r_state != S_ERROR);
   assign w_ld_nxt    = w_in_ld  ? sat_inc(r_cnt_ld)  : r_cnt_ld;
   assign w_mac_nxt   = w_in_mac ? sat_inc(r_cnt_mac) : r_cnt_mac;
   assign w_tot_nxt   = w_busy   ? sat_inc(r_cnt_tot) : r_cnt_tot;
   // Working phase counters double as the watchdog: both clear before each phase.
   assign w_phase_nxt = w_in_ld ? w_ld_nxt : w_mac_nxt;
   assign w_wd_hit    = (TIMEOUT != 0) && (64'(w_phase_nxt) >= TO64);
   assign w_skip_mac  = (r_ntaps == '0);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Completion wins over the watchdog when both land on the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (ap_start) w_state_nxt = S_LD_START;
         S_LD_START:
            if (ld_ready && ld_done) w_state_nxt = w_skip_mac ? S_DONE : S_MAC_START;
            else if (w_wd_hit)       w_state_nxt = S_ERROR;
            else if (ld_ready)       w_state_nxt = S_LD_WAIT;
         S_LD_WAIT:
            if (ld_done)             w_state_nxt = w_skip_mac ? S_DONE : S_MAC_START;
            else if (w_wd_hit)       w_state_nxt = S_ERROR;
         S_MAC_START:
            if (mac_ready && mac_done) w_state_nxt = S_DONE;
            else if (w_wd_hit)         w_state_nxt = S_ERROR;
            else if (mac_ready)        w_state_nxt = S_MAC_WAIT;
         S_MAC_WAIT:
            if (mac_done)            w_state_nxt = S_DONE;
            else if (w_wd_hit)       w_state_nxt = S_ERROR;
         S_DONE:
            w_state_nxt = S_IDLE;
         S_ERROR:
            if (err_clr) w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_cnt_ld    <= '0;
         r_cnt_mac   <= '0;
         r_cnt_tot   <= '0;
         r_ntaps     <= '0;
         r_lat_load  <= '0;
         r_lat_mac   <= '0;
         r_lat_total <= '0;
      end else begin
         if ((r_state == S_IDLE) && ap_start) begin
            r_cnt_ld  <= '0;
            r_cnt_mac <= '0;
            r_cnt_tot <= '0;
            r_ntaps   <= cfg_ntaps;
         end else begin
            r_cnt_ld  <= w_ld_nxt;
            r_cnt_mac <= w_mac_nxt;
            r_cnt_tot <= w_tot_nxt;
         end
         // lat_total also covers the DONE cycle itself, hence the extra increment.
         if (w_enter_done) begin
            r_lat_load  <= w_ld_nxt;
            r_lat_mac   <= w_mac_nxt;
            r_lat_total <= sat_inc(w_tot_nxt);
         end
      end
   end

   assign ap_idle     = (r_state == S_IDLE);
   assign ap_done     = (r_state == S_DONE);
   assign ap_ready    = (r_state == S_DONE);
   assign lat_valid   = (r_state == S_DONE);
   assign ld_start    = (r_state == S_LD_START);
   assign mac_start   = (r_state == S_MAC_START);
   assign err_timeout = (r_state == S_ERROR);
   assign mac_ntaps   = r_ntaps;
   assign lat_load    = r_lat_load;
   assign lat_mac     = r_lat_mac;
   assign lat_total   = r_lat_total;

endmodule

// File: tb/tb_fir_loop_sequencer.sv
// Bench for fir_loop_sequencer: run-level model of phase lengths drives stubs
// and per-cycle expectations; literal latencies/pulse widths pin the model.
module tb_fir_loop_sequencer;
   localparam int CNT_W   = 32;
   localparam int NTAPS_W = 8;
   localparam int TO      = 10;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n, ap_start, ap_done, ap_idle, ap_ready;
   logic [NTAPS_W-1:0] cfg_ntaps, mac_ntaps;
   logic               ld_start, ld_ready, ld_done;
   logic               mac_start, mac_ready, mac_done;
   logic [CNT_W-1:0]   lat_load, lat_mac, lat_total;
   logic               lat_valid, err_timeout, err_clr;

   always #5 ap_clk = ~ap_clk;

   fir_loop_sequencer #(.CNT_W(CNT_W), .NTAPS_W(NTAPS_W), .TIMEOUT(TO)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .cfg_ntaps(cfg_ntaps),
      .ld_start(ld_start), .ld_ready(ld_ready), .ld_done(ld_done),
      .mac_start(mac_start), .mac_ready(mac_ready), .mac_done(mac_done),
      .mac_ntaps(mac_ntaps), .lat_load(lat_load), .lat_mac(lat_mac),
      .lat_total(lat_total), .lat_valid(lat_valid), .err_timeout(err_timeout),
      .err_clr(err_clr)
   );

   // Expected outputs for the current cycle, set just after each rising edge.
   bit chk_en, e_idle, e_ld, e_mac, e_done, e_err, e_acc, lit_en;
   int e_ntaps, e_lload, e_lmac, e_ltot;
   int lit_lload, lit_lmac, lit_ltot, lit_ldhi, lit_machi;
   // Run-level model: latched tap count and last published latencies.
   int m_ntaps, m_lload, m_lmac, m_ltot;

   int n_chk = 0, n_fail = 0;
   int ldhi, machi;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   always @(negedge ap_clk) begin
      if (chk_en) begin
         if (e_acc) begin
            ldhi  = 0;
            machi = 0;
         end
         if (ld_start)  ldhi++;
         if (mac_start) machi++;
         chk("ap_idle",     32'(ap_idle),     32'(e_idle));
         chk("ld_start",    32'(ld_start),    32'(e_ld));
         chk("mac_start",   32'(mac_start),   32'(e_mac));
         chk("ap_done",     32'(ap_done),     32'(e_done));
         chk("ap_ready",    32'(ap_ready),    32'(e_done));
         chk("lat_valid",   32'(lat_valid),   32'(e_done));
         chk("err_timeout", 32'(err_timeout), 32'(e_err));
         chk("mac_ntaps",   32'(mac_ntaps),   32'(e_ntaps));
         chk("lat_load",    lat_load,         32'(e_lload));
         chk("lat_mac",     lat_mac,          32'(e_lmac));
         chk("lat_total",   lat_total,        32'(e_ltot));
         if (lit_en) begin
            chk("lit lat_load",        lat_load,    32'(lit_lload));
            chk("lit lat_mac",         lat_mac,     32'(lit_lmac));
            chk("lit lat_total",       lat_total,   32'(lit_ltot));
            chk("lit ld_start cycles", 32'(ldhi),   32'(lit_ldhi));
            chk("lit mac_start cycles",32'(machi),  32'(lit_machi));
         end
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_out(input bit idle, input bit ld, input bit mac, input bit done, input bit err);
      e_idle = idle; e_ld = ld; e_mac = mac; e_done = done; e_err = err;
      e_ntaps = m_ntaps; e_lload = m_lload; e_lmac = m_lmac; e_ltot = m_ltot;
      e_acc = 1'b0; lit_en = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_out(1, 0, 0, 0, 0);
         tick();
      end
   endtask

   // One run: stubs raise ready/done on the given 1-based phase cycle (0 = never).
   // LOAD lasts ldn cycles, MAC mdn cycles, then one DONE cycle.
   task automatic run(input int ntaps, input int lr, input int ldn, input int mr, input int mdn,
                      input bit hold, input bit stray, input int rst_k, input bit lit,
                      input int l_ld, input int l_mac, input int l_tot,
                      input int l_ldhi, input int l_machi);
      int  len_l, len_m;
      bit  ph_done;
      ap_start  = 1'b1;
      cfg_ntaps = NTAPS_W'(ntaps);
      set_out(1, 0, 0, 0, 0);
      e_acc = 1'b1;
      tick();
      m_ntaps   = ntaps;
      ap_start  = hold;
      cfg_ntaps = ~NTAPS_W'(ntaps);
      len_l = 0; len_m = 0; ph_done = 1'b0;
      for (int k = 1; k <= TO && !ph_done; k++) begin
         ld_ready  = (k == lr);
         ld_done   = (k == ldn);
         mac_ready = stray && (k == 2);
         mac_done  = stray && (k == 2);
         set_out(0, k <= lr, 0, 0, 0);
         tick();
         if (k == ldn) begin
            len_l = k;
            ph_done = 1'b1;
         end
      end
      ld_ready = 1'b0; ld_done = 1'b0; mac_ready = 1'b0; mac_done = 1'b0;
      if (!ph_done) return;
      if (ntaps != 0) begin
         ph_done = 1'b0;
         for (int k = 1; k <= TO && !ph_done; k++) begin
            mac_ready = (k == mr);
            mac_done  = (k == mdn);
            set_out(0, 0, k <= mr, 0, 0);
            if (k == rst_k) begin
               #2 ap_rst_n = 1'b0;
               #1;
               m_ntaps = 0; m_lload = 0; m_lmac = 0; m_ltot = 0;
               mac_ready = 1'b0; mac_done = 1'b0;
               set_out(1, 0, 0, 0, 0);
               tick();
               ap_rst_n = 1'b1;
               return;
            end
            tick();
            if (k == mdn) begin
               len_m = k;
               ph_done = 1'b1;
            end
         end
         mac_ready = 1'b0; mac_done = 1'b0;
      end
      m_lload = len_l;
      m_lmac  = len_m;
      m_ltot  = len_l + len_m + 1;
      set_out(0, 0, 0, 1, 0);
      lit_en = lit;
      lit_lload = l_ld; lit_lmac = l_mac; lit_ltot = l_tot;
      lit_ldhi = l_ldhi; lit_machi = l_machi;
      tick();
   endtask

   initial begin
      ap_rst_n = 1'b0; ap_start = 1'b0; cfg_ntaps = '0; err_clr = 1'b0;
      ld_ready = 1'b0; ld_done = 1'b0; mac_ready = 1'b0; mac_done = 1'b0;
      m_ntaps = 0; m_lload = 0; m_lmac = 0; m_ltot = 0;
      set_out(1, 0, 0, 0, 0);
      chk_en = 1'b1;
      tick();
      tick();
      ap_rst_n = 1'b1;
      idle_cycles(2);

      // Basic run
      run(16, 1, 4, 1, 1, 0, 0, 0, 1, 4, 1, 6, 1, 1);
      idle_cycles(2);
      // Delayed MAC ready
      run(16, 1, 4, 6, 8, 0, 0, 0, 1, 4, 8, 13, 1, 6);
      idle_cycles(2);
      // MAC skipped
      run(0, 1, 4, 1, 1, 0, 0, 0, 1, 4, 0, 5, 1, 0);
      idle_cycles(2);

      // Watchdog: LOAD never finishes
      run(16, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ap_start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_out(0, 0, 0, 0, 1);
         tick();
      end
      ap_start = 1'b0;
      err_clr  = 1'b1;
      set_out(0, 0, 0, 0, 1);
      tick();
      set_out(1, 0, 0, 0, 0);
      tick();
      err_clr = 1'b0;
      idle_cycles(1);
      run(16, 1, 4, 1, 1, 0, 0, 0, 1, 4, 1, 6, 1, 1);
      idle_cycles(2);

      // Reset during MAC_WAIT, then a clean run
      run(16, 1, 4, 6, 8, 0, 0, 7, 0, 0, 0, 0, 0, 0);
      idle_cycles(2);
      run(16, 1, 4, 1, 1, 0, 0, 0, 1, 4, 1, 6, 1, 1);
      idle_cycles(2);

      // Back-to-back with ap_start held and stray MAC handshakes during LOAD
      run(16, 1, 4, 1, 1, 1, 1, 0, 1, 4, 1, 6, 1, 1);
      run(9, 2, 3, 1, 2, 0, 0, 0, 1, 3, 2, 6, 2, 1);
      idle_cycles(3);

      chk_en = 1'b0;
      #1;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_loop_sequencer.md
Name: fir_loop_sequencer

Overview:
- Top-level ap_ctrl_hs controller for the FIR datapath.
- Sequences two HLS pipelined sub-blocks: the sample-load/shift loop (LOAD) and the tap MAC loop (MAC). LOAD runs to completion, then MAC.
- Publishes per-run cycle counts for performance dumps and a timeout watchdog so a hung sub-block does not stall the system silently.

Parameters:
- CNT_W, 32, width of latency counters
- NTAPS_W, 8, width of tap-count configuration
- TIMEOUT, 65536, max cycles allowed per phase before error; 0 disables the watchdog

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  top start request
- ap_done  out  1  top done pulse
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  top ready pulse
- cfg_ntaps  in  NTAPS_W  tap count, latched at start
- ld_start  out  1  LOAD ap_start
- ld_ready  in  1  LOAD ap_ready
- ld_done  in  1  LOAD ap_done
- mac_start  out  1  MAC ap_start
- mac_ready  in  1  MAC ap_ready
- mac_done  in  1  MAC ap_done
- mac_ntaps  out  NTAPS_W  latched tap count to MAC trip-count input
- lat_load  out  CNT_W  cycles spent in LOAD phase, last run
- lat_mac  out  CNT_W  cycles spent in MAC phase, last run
- lat_total  out  CNT_W  cycles from start acceptance to done, last run
- lat_valid  out  1  one-cycle pulse when lat_* update
- err_timeout  out  1  sticky watchdog error
- err_clr  in  1  clears error, returns to IDLE

Behaviour:
- Reset: ap_rst_n low forces IDLE immediately, asynchronously, including mid-run.
  - All outputs go to 0, except ap_idle=1.
  - lat_* = 0, mac_ntaps = 0, err_timeout = 0.
- States: IDLE, LD_START, LD_WAIT, MAC_START, MAC_WAIT, DONE, ERROR. All outputs are registered or decoded from state; no combinational path from ld_*/mac_* to outputs.
- IDLE:
  - ap_idle=1.
  - On ap_start=1: latch cfg_ntaps into mac_ntaps, clear working counters, go to LD_START.
- LD_START:
  - ld_start=1, held until ld_ready is sampled high (ap_ctrl_hs rule).
  - ld_ready=1 and ld_done=1 in the same cycle: go straight to MAC_START.
  - ld_ready=1 only: go to LD_WAIT.
- LD_WAIT:
  - ld_start=0.
  - ld_done=1: go to MAC_START, or to DONE if latched ntaps==0 (MAC skipped, lat_mac=0).
- MAC_START / MAC_WAIT: identical rules using mac_* signals; completion goes to DONE.
- DONE (exactly 1 cycle):
  - ap_done=1, ap_ready=1, lat_valid=1.
  - lat_* outputs take working counter values this cycle and hold until the next DONE.
  - Next state is IDLE. ap_start is not sampled in DONE.
  - Minimum start-to-start interval is therefore (phase cycles + 2).
- Counters:
  - Working load counter increments every cycle in LD_START/LD_WAIT.
  - Working MAC counter increments every cycle in MAC_START/MAC_WAIT.
  - Total counter increments every cycle in every non-IDLE, non-ERROR state, including DONE.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Watchdog:
  - Per-phase counter clears on entry to LD_START and MAC_START.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT while in a START/WAIT state: go to ERROR and set err_timeout=1.
  - Timeout is checked after that cycle's ready/done, so done on the TIMEOUT-th cycle still completes normally.
- ERROR:
  - ld_start=mac_start=0, ap_done=0, ap_idle=0, lat_* unchanged.
  - err_clr=1 clears err_timeout and goes to IDLE.
  - err_clr in any other state has no effect.
- Stray ld_ready/ld_done/mac_ready/mac_done outside their own phase states are ignored.
- ap_start deasserted mid-run has no effect; a run, once accepted, completes or times out.

Test Plan:
- Basic run, cfg_ntaps=16:
  - LOAD stub: ready on 1st LD_START cycle, done 3 cycles later.
  - MAC stub: ready and done together on 1st cycle.
  - Required: ld_start high 1 cycle; mac_ntaps=16; ap_done/ap_ready/lat_valid single pulse; lat_load=4, lat_mac=1, lat_total=6; ap_idle high next cycle.
- Delayed ready: MAC stub withholds mac_ready 5 cycles, done 2 cycles after ready -> mac_start high exactly 6 cycles, lat_mac=8.
- ntaps=0: LOAD as in the basic run -> mac_start never asserts, lat_mac=0, lat_total=5.
- Timeout, TIMEOUT=10: LOAD never asserts ld_done -> ERROR after 10 LOAD cycles; err_timeout=1; ap_done never pulses; ap_start ignored. err_clr pulse -> IDLE, err_timeout=0, next run completes normally.
- Reset mid-run: drop ap_rst_n during MAC_WAIT -> outputs immediately at reset values (mac_start=0, ap_idle=1, lat_*=0); a run after release behaves as the basic run.
- Back-to-back: ap_start held high across two runs -> second LOAD starts the cycle after IDLE is re-entered; two distinct lat_valid pulses; stray mac_done during LOAD is ignored.
